// File: rtl/gpio_apb_arbiter2.sv
// Two-requester APB2 master for the GPIO lite slave registers.
// It arbitrates single 16-bit read/write commands from A and B and returns read data.
//
// state  | meaning
// IDLE   | no transfer; arbitrate eligible requesters
// SETUP  | psel2=1, penable2=0
// ACCESS | psel2=1, penable2=1; capture read data on exit
module gpio_apb_arbiter2 #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic              pclk2,
  input  logic              n_p_reset2,
  input  logic              req_a2,
  input  logic              we_a2,
  input  logic [ADDR_W-1:0] addr_a2,
  input  logic [DATA_W-1:0] wdata_a2,
  output logic              done_a2,
  output logic [DATA_W-1:0] rdata_a2,
  input  logic              req_b2,
  input  logic              we_b2,
  input  logic [ADDR_W-1:0] addr_b2,
  input  logic [DATA_W-1:0] wdata_b2,
  output logic              done_b2,
  output logic [DATA_W-1:0] rdata_b2,
  output logic              busy2,
  output logic              psel2,
  output logic              penable2,
  output logic              pwrite2,
  output logic [ADDR_W-1:0] paddr2,
  output logic [31:0]       pwdata2,
  input  logic [31:0]       prdata2
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]  state;
  logic        gnt_b;
  logic        rr_b_next;
  logic        elig_a;
  logic        elig_b;
  logic        pick_b;
  logic [31:0] wdata_ext;

  // A requester that is showing done this cycle is masked so a held req
  // cannot be mistaken for a new command before it has seen completion.
  always_comb begin
    elig_a = req_a2 & ~done_a2;
    elig_b = req_b2 & ~done_b2;
    pick_b = 1'b0;
    if (elig_a && elig_b) begin
      pick_b = (FIXED_PRI != 0) ? 1'b0 : rr_b_next;
    end else begin
      pick_b = elig_b;
    end
    wdata_ext = '0;
    wdata_ext[DATA_W-1:0] = pick_b ? wdata_b2 : wdata_a2;
  end

  always_ff @(posedge pclk2 or negedge n_p_reset2) begin
    if (!n_p_reset2) begin
      state     <= ST_IDLE;
      gnt_b     <= 1'b0;
      rr_b_next <= 1'b0;
      psel2     <= 1'b0;
      penable2  <= 1'b0;
      pwrite2   <= 1'b0;
      paddr2    <= '0;
      pwdata2   <= '0;
      done_a2   <= 1'b0;
      done_b2   <= 1'b0;
      rdata_a2  <= '0;
      rdata_b2  <= '0;
    end else begin
      done_a2 <= 1'b0;
      done_b2 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (elig_a || elig_b) begin
            state     <= ST_SETUP;
            psel2     <= 1'b1;
            gnt_b     <= pick_b;
            rr_b_next <= ~pick_b;
            pwrite2   <= pick_b ? we_b2 : we_a2;
            paddr2    <= pick_b ? addr_b2 : addr_a2;
            pwdata2   <= wdata_ext;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          penable2 <= 1'b1;
        end
        ST_ACCESS: begin
          state    <= ST_IDLE;
          psel2    <= 1'b0;
          penable2 <= 1'b0;
          if (gnt_b) begin
            done_b2 <= 1'b1;
            if (!pwrite2) rdata_b2 <= prdata2[DATA_W-1:0];
          end else begin
            done_a2 <= 1'b1;
            if (!pwrite2) rdata_a2 <= prdata2[DATA_W-1:0];
          end
        end
        default: begin
          state    <= ST_IDLE;
          psel2    <= 1'b0;
          penable2 <= 1'b0;
        end
      endcase
    end
  end

  assign busy2 = (state == ST_SETUP) || (state == ST_ACCESS);

  generate
    if (DATA_W < 32) begin : g_unused_prdata
      logic unused_prdata;
      assign unused_prdata = ^prdata2[31:DATA_W];
    end
  endgenerate

endmodule

// File: tb/tb_gpio_apb_arbiter2.sv
// Directed bench for gpio_apb_arbiter2: a round-robin instance and a fixed-priority
// instance share the same stimulus; expected values are hand-computed.
module tb_gpio_apb_arbiter2;

  logic        pclk2 = 1'b0;
  logic        n_p_reset2;
  logic        req_a2, we_a2, req_b2, we_b2;
  logic [5:0]  addr_a2, addr_b2;
  logic [15:0] wdata_a2, wdata_b2;
  logic [31:0] prdata2;

  logic        done_a2, done_b2, busy2, psel2, penable2, pwrite2;
  logic [15:0] rdata_a2, rdata_b2;
  logic [5:0]  paddr2;
  logic [31:0] pwdata2;

  logic        done_a2_f, done_b2_f, busy2_f, psel2_f, penable2_f, pwrite2_f;
  logic [15:0] rdata_a2_f, rdata_b2_f;
  logic [5:0]  paddr2_f;
  logic [31:0] pwdata2_f;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk2 = ~pclk2;

  gpio_apb_arbiter2 #(.ADDR_W(6), .DATA_W(16), .FIXED_PRI(0)) dut (
    .pclk2(pclk2), .n_p_reset2(n_p_reset2),
    .req_a2(req_a2), .we_a2(we_a2), .addr_a2(addr_a2), .wdata_a2(wdata_a2),
    .done_a2(done_a2), .rdata_a2(rdata_a2),
    .req_b2(req_b2), .we_b2(we_b2), .addr_b2(addr_b2), .wdata_b2(wdata_b2),
    .done_b2(done_b2), .rdata_b2(rdata_b2),
    .busy2(busy2), .psel2(psel2), .penable2(penable2), .pwrite2(pwrite2),
    .paddr2(paddr2), .pwdata2(pwdata2), .prdata2(prdata2)
  );

  gpio_apb_arbiter2 #(.ADDR_W(6), .DATA_W(16), .FIXED_PRI(1)) dut_fp (
    .pclk2(pclk2), .n_p_reset2(n_p_reset2),
    .req_a2(req_a2), .we_a2(we_a2), .addr_a2(addr_a2), .wdata_a2(wdata_a2),
    .done_a2(done_a2_f), .rdata_a2(rdata_a2_f),
    .req_b2(req_b2), .we_b2(we_b2), .addr_b2(addr_b2), .wdata_b2(wdata_b2),
    .done_b2(done_b2_f), .rdata_b2(rdata_b2_f),
    .busy2(busy2_f), .psel2(psel2_f), .penable2(penable2_f), .pwrite2(pwrite2_f),
    .paddr2(paddr2_f), .pwdata2(pwdata2_f), .prdata2(prdata2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge pclk2);
  endtask

  logic [5:0] q_main[$];
  logic [5:0] q_fp[$];
  int         done_k[$];
  logic       prev_done_a_f;

  // Hold both requesters for 12 cycles, logging granted addresses at SETUP.
  task automatic run_both_held();
    q_main.delete(); q_fp.delete(); done_k.delete();
    prev_done_a_f = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (psel2 && !penable2) q_main.push_back(paddr2);
      if (psel2_f && !penable2_f) begin
        q_fp.push_back(paddr2_f);
        if (paddr2_f == 6'h20) chk("fp_b_only_when_a_masked", {31'd0, prev_done_a_f}, 32'd1);
      end
      if (done_a2 || done_b2) done_k.push_back(k);
      prev_done_a_f = done_a2_f;
      if (k == 12) begin
        req_a2 = 1'b0;
        req_b2 = 1'b0;
      end
    end
  endtask

  initial begin
    n_p_reset2 = 1'b0;
    req_a2 = 0; we_a2 = 0; addr_a2 = '0; wdata_a2 = '0;
    req_b2 = 0; we_b2 = 0; addr_b2 = '0; wdata_b2 = '0;
    prdata2 = '0;

    // 1: random inputs during reset
    for (int i = 0; i < 4; i++) begin
      req_a2 = 1'($urandom); we_a2 = 1'($urandom); addr_a2 = 6'($urandom); wdata_a2 = 16'($urandom);
      req_b2 = 1'($urandom); we_b2 = 1'($urandom); addr_b2 = 6'($urandom); wdata_b2 = 16'($urandom);
      prdata2 = $urandom;
      cyc();
      chk("rst_ctrl", {26'd0, psel2, penable2, pwrite2, busy2, done_a2, done_b2}, 32'd0);
      chk("rst_paddr", {26'd0, paddr2}, 32'd0);
      chk("rst_pwdata", pwdata2, 32'd0);
      chk("rst_rdata", {rdata_a2, rdata_b2}, 32'd0);
    end
    req_a2 = 0; req_b2 = 0; prdata2 = '0;
    n_p_reset2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_psel", {31'd0, psel2}, 32'd0);
    end

    // 2: A write 04 <- 00FF
    req_a2 = 1; we_a2 = 1; addr_a2 = 6'h04; wdata_a2 = 16'h00FF;
    cyc();
    chk("wr_setup_psel_pen", {30'd0, psel2, penable2}, 32'h2);
    chk("wr_setup_busy", {31'd0, busy2}, 32'd1);
    chk("wr_paddr", {26'd0, paddr2}, 32'h04);
    chk("wr_pwdata", pwdata2, 32'h0000_00FF);
    chk("wr_pwrite", {31'd0, pwrite2}, 32'd1);
    we_a2 = 0; addr_a2 = 6'h3F; wdata_a2 = 16'hFFFF;
    cyc();
    chk("wr_access_psel_pen", {30'd0, psel2, penable2}, 32'h3);
    chk("wr_access_stable", {25'd0, pwrite2, paddr2}, {25'd0, 1'b1, 6'h04});
    chk("wr_access_pwdata", pwdata2, 32'h0000_00FF);
    cyc();
    chk("wr_done_a", {30'd0, done_a2, done_b2}, 32'h2);
    chk("wr_done_psel_pen", {29'd0, psel2, penable2, busy2}, 32'd0);
    chk("wr_rdata_a_unchanged", {16'd0, rdata_a2}, 32'd0);
    chk("wr_hold_paddr", {26'd0, paddr2}, 32'h04);
    req_a2 = 0;
    cyc();
    chk("wr_done_one_cycle", {30'd0, done_a2, psel2}, 32'd0);

    // 3: B read 08, slave returns DEAD1234 in ACCESS
    req_b2 = 1; we_b2 = 0; addr_b2 = 6'h08; prdata2 = 32'h0;
    cyc();
    chk("rd_setup_paddr", {26'd0, paddr2}, 32'h08);
    chk("rd_setup_pwrite", {31'd0, pwrite2}, 32'd0);
    prdata2 = 32'hDEAD_1234;
    cyc();
    chk("rd_access_pen", {31'd0, penable2}, 32'd1);
    cyc();
    prdata2 = 32'h0;
    chk("rd_done_b", {30'd0, done_a2, done_b2}, 32'h1);
    chk("rd_rdata_b", {16'd0, rdata_b2}, 32'h1234);
    chk("rd_rdata_a_untouched", {16'd0, rdata_a2}, 32'd0);
    req_b2 = 0;
    cyc();
    chk("rd_rdata_b_held", {16'd0, rdata_b2}, 32'h1234);

    // 4: both held, pointer says A next
    req_a2 = 1; we_a2 = 1; addr_a2 = 6'h10; wdata_a2 = 16'h1111;
    req_b2 = 1; we_b2 = 0; addr_b2 = 6'h20; prdata2 = 32'h0000_5A5A;
    run_both_held();
    chk("rr_grants", {26'd0, 6'(q_main.size())}, 32'd4);
    if (q_main.size() == 4) begin
      chk("rr_g0", {26'd0, q_main[0]}, 32'h10);
      chk("rr_g1", {26'd0, q_main[1]}, 32'h20);
      chk("rr_g2", {26'd0, q_main[2]}, 32'h10);
      chk("rr_g3", {26'd0, q_main[3]}, 32'h20);
    end
    chk("rr_dones", {26'd0, 6'(done_k.size())}, 32'd4);
    if (done_k.size() == 4) begin
      chk("rr_done_first", 32'(done_k[0]), 32'd3);
      for (int i = 1; i < 4; i++) chk("rr_done_spacing", 32'(done_k[i] - done_k[i-1]), 32'd3);
    end
    chk("rr_rdata_b", {16'd0, rdata_b2}, 32'h5A5A);
    cyc();
    chk("rr_idle_after", {31'd0, psel2}, 32'd0);

    // lone A write moves the round-robin pointer to B
    req_a2 = 1; we_a2 = 1; addr_a2 = 6'h30; wdata_a2 = 16'h2222;
    cyc(); cyc(); cyc();
    chk("lone_a_done", {31'd0, done_a2}, 32'd1);
    req_a2 = 0;
    cyc();

    // 5: tie with pointer at B; fixed priority must still pick A
    req_a2 = 1; we_a2 = 1; addr_a2 = 6'h10; wdata_a2 = 16'h1111;
    req_b2 = 1; we_b2 = 0; addr_b2 = 6'h20;
    run_both_held();
    chk("rr2_grants", {26'd0, 6'(q_main.size())}, 32'd4);
    if (q_main.size() == 4) begin
      chk("rr2_g0", {26'd0, q_main[0]}, 32'h20);
      chk("rr2_g1", {26'd0, q_main[1]}, 32'h10);
    end
    chk("fp_grants", {26'd0, 6'(q_fp.size())}, 32'd4);
    if (q_fp.size() == 4) begin
      chk("fp_g0", {26'd0, q_fp[0]}, 32'h10);
      chk("fp_g1", {26'd0, q_fp[1]}, 32'h20);
      chk("fp_g2", {26'd0, q_fp[2]}, 32'h10);
      chk("fp_g3", {26'd0, q_fp[3]}, 32'h20);
    end
    cyc();

    // 6: reset during ACCESS abandons the transfer
    req_a2 = 1; we_a2 = 1; addr_a2 = 6'h3C; wdata_a2 = 16'hABCD;
    cyc();
    cyc();
    chk("abort_in_access", {30'd0, psel2, penable2}, 32'h3);
    #2 n_p_reset2 = 1'b0;
    #1 chk("abort_psel_pen_drop", {28'd0, psel2, penable2, psel2_f, penable2_f}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("abort_no_done", {30'd0, done_a2, done_b2}, 32'd0);
    end
    n_p_reset2 = 1'b1;
    cyc();
    chk("reissue_setup", {24'd0, psel2, penable2, paddr2}, {24'd0, 2'b10, 6'h3C});
    cyc();
    chk("reissue_access_pwdata", pwdata2, 32'h0000_ABCD);
    cyc();
    chk("reissue_done", {30'd0, done_a2, done_b2}, 32'h2);
    req_a2 = 0;
    cyc();
    chk("reissue_end_idle", {30'd0, psel2, done_a2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
